// File: rtl/otp_macro_arb.sv
// otp_macro_arb: shares one OTP macro between NumReq requesters.
// It owns the macro init handshake and grants commands round-robin, one at a time.
// Each program is followed by a read-back, and the response flags any requested
// bit that did not get set. A read or read-back that never returns is aborted
// after TimeoutCycles.
//
// state      | meaning
// -----------+-----------------------------------------------------
// ResetSt    | just out of reset, macro untouched
// InitSt     | otp_init_req_o high, waiting for otp_init_done_i
// IdleSt     | arbitrating, winner's command presented to the macro
// RdWaitSt   | read accepted, waiting for otp_rvalid_i
// WrBusySt   | program accepted, macro busy for one cycle
// VfyReqSt   | issuing read-back of the programmed address
// VfyWaitSt  | waiting for read-back data, then bit check
module otp_macro_arb #(
  parameter int NumReq        = 3,
  parameter int Width         = 16,
  parameter int Depth         = 1024,
  parameter int TimeoutCycles = 16,
  localparam int AddrWidth    = $clog2(Depth)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NumReq-1:0]           req_valid_i,
  output logic [NumReq-1:0]           req_ready_o,
  input  logic [NumReq-1:0]           req_wren_i,
  input  logic [NumReq*AddrWidth-1:0] req_addr_i,
  input  logic [NumReq*Width-1:0]     req_wdata_i,
  output logic [NumReq-1:0]           rsp_valid_o,
  output logic [Width-1:0]            rsp_rdata_o,
  output logic                        rsp_err_o,
  output logic                        init_done_o,
  output logic                        otp_init_req_o,
  input  logic                        otp_init_done_i,
  output logic                        otp_valid_o,
  input  logic                        otp_ready_i,
  output logic                        otp_wren_o,
  output logic [AddrWidth-1:0]        otp_addr_o,
  output logic [Width-1:0]            otp_wdata_o,
  input  logic [Width-1:0]            otp_rdata_i,
  input  logic                        otp_rvalid_i
);

  localparam int IdxWidth = $clog2(NumReq);
  localparam int CntWidth = $clog2(TimeoutCycles);

  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumReq - 1);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);

  localparam logic [2:0] ResetSt   = 3'd0;
  localparam logic [2:0] InitSt    = 3'd1;
  localparam logic [2:0] IdleSt    = 3'd2;
  localparam logic [2:0] RdWaitSt  = 3'd3;
  localparam logic [2:0] WrBusySt  = 3'd4;
  localparam logic [2:0] VfyReqSt  = 3'd5;
  localparam logic [2:0] VfyWaitSt = 3'd6;

  logic [2:0]          state_q;
  logic [IdxWidth-1:0] rr_q;
  logic [IdxWidth-1:0] grant_q;
  logic [AddrWidth-1:0] addr_q;
  logic [Width-1:0]    wdata_q;
  logic                wren_q;
  logic [CntWidth-1:0] cnt_q;
  logic                init_done_q;
  logic [NumReq-1:0]   rsp_valid_q;
  logic [Width-1:0]    rsp_rdata_q;
  logic                rsp_err_q;

  logic                any_valid;
  logic [IdxWidth-1:0] win_idx;
  logic                win_wren;
  logic [AddrWidth-1:0] win_addr;
  logic [Width-1:0]    win_wdata;
  logic                accept;
  logic [NumReq-1:0]   grant_oh;
  logic                vfy_mismatch;

  // Round-robin search: scan downwards so the nearest requester at/after rr_q wins last.
  always_comb begin
    int j;
    any_valid = 1'b0;
    win_idx   = '0;
    j         = 0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      j = int'(rr_q) + k;
      if (j >= NumReq) j = j - NumReq;
      if (req_valid_i[j]) begin
        any_valid = 1'b1;
        win_idx   = IdxWidth'(j);
      end
    end
  end

  assign win_wren  = req_wren_i[win_idx];
  assign win_addr  = req_addr_i[win_idx*AddrWidth +: AddrWidth];
  assign win_wdata = req_wdata_i[win_idx*Width +: Width];
  assign accept    = (state_q == IdleSt) && any_valid && otp_ready_i;

  // One-hot of the latched grant, used to steer the response.
  always_comb begin
    grant_oh          = '0;
    grant_oh[grant_q] = 1'b1;
  end

  // A read-back only passes if every bit we asked to program reads as set.
  assign vfy_mismatch = (otp_rdata_i & wdata_q) != wdata_q;

  // Macro command bus: live winner in IdleSt, latched address during read-back, else quiet.
  always_comb begin
    otp_valid_o = 1'b0;
    otp_wren_o  = 1'b0;
    otp_addr_o  = '0;
    otp_wdata_o = '0;
    req_ready_o = '0;
    case (state_q)
      IdleSt: begin
        if (any_valid) begin
          otp_valid_o = 1'b1;
          otp_wren_o  = win_wren;
          otp_addr_o  = win_addr;
          otp_wdata_o = win_wdata;
          if (otp_ready_i) req_ready_o[win_idx] = 1'b1;
        end
      end
      VfyReqSt: begin
        otp_valid_o = 1'b1;
        otp_addr_o  = addr_q;
      end
      default: ;
    endcase
  end

  assign otp_init_req_o = (state_q == InitSt);
  assign init_done_o    = init_done_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_rdata_o    = rsp_rdata_q;
  assign rsp_err_o      = rsp_err_q;

  // Sequencer: init handshake, grant latching, wait/timeout and registered one-cycle responses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ResetSt;
      rr_q        <= '0;
      grant_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wren_q      <= 1'b0;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      case (state_q)
        ResetSt: state_q <= InitSt;
        InitSt: begin
          if (otp_init_done_i) begin
            state_q     <= IdleSt;
            init_done_q <= 1'b1;
          end
        end
        IdleSt: begin
          if (accept) begin
            grant_q <= win_idx;
            addr_q  <= win_addr;
            wdata_q <= win_wdata;
            wren_q  <= win_wren;
            rr_q    <= (win_idx == LastIdx) ? '0 : win_idx + 1'b1;
            cnt_q   <= '0;
            state_q <= win_wren ? WrBusySt : RdWaitSt;
          end
        end
        RdWaitSt, VfyWaitSt: begin
          if (otp_rvalid_i) begin
            rsp_valid_q <= grant_oh;
            rsp_rdata_q <= otp_rdata_i;
            rsp_err_q   <= wren_q && vfy_mismatch;
            state_q     <= IdleSt;
          end else if (cnt_q == CntLast) begin
            rsp_valid_q <= grant_oh;
            rsp_err_q   <= 1'b1;
            state_q     <= IdleSt;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WrBusySt: state_q <= VfyReqSt;
        VfyReqSt: begin
          if (otp_ready_i) begin
            cnt_q   <= '0;
            state_q <= VfyWaitSt;
          end
        end
        default: state_q <= ResetSt;
      endcase
    end
  end

endmodule

// File: tb/tb_otp_macro_arb.sv
// Bench for otp_macro_arb: a behavioural OTP macro plus a response scoreboard.
module tb_otp_macro_arb;

  localparam int NumReq = 3;
  localparam int Width  = 16;
  localparam int Depth  = 1024;
  localparam int AW     = 10;
  localparam int TO     = 16;

  logic                   clk_i = 1'b0;
  logic                   rst_ni;
  logic [NumReq-1:0]      req_valid_i;
  logic [NumReq-1:0]      req_ready_o;
  logic [NumReq-1:0]      req_wren_i;
  logic [NumReq*AW-1:0]   req_addr_i;
  logic [NumReq*Width-1:0] req_wdata_i;
  logic [NumReq-1:0]      rsp_valid_o;
  logic [Width-1:0]       rsp_rdata_o;
  logic                   rsp_err_o;
  logic                   init_done_o;
  logic                   otp_init_req_o;
  logic                   otp_init_done_i;
  logic                   otp_valid_o;
  logic                   otp_ready_i;
  logic                   otp_wren_o;
  logic [AW-1:0]          otp_addr_o;
  logic [Width-1:0]       otp_wdata_o;
  logic [Width-1:0]       otp_rdata_i;
  logic                   otp_rvalid_i;

  otp_macro_arb #(.NumReq(NumReq), .Width(Width), .Depth(Depth), .TimeoutCycles(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_wren_i(req_wren_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .init_done_o(init_done_o), .otp_init_req_o(otp_init_req_o), .otp_init_done_i(otp_init_done_i),
    .otp_valid_o(otp_valid_o), .otp_ready_i(otp_ready_i), .otp_wren_o(otp_wren_o),
    .otp_addr_o(otp_addr_o), .otp_wdata_o(otp_wdata_o),
    .otp_rdata_i(otp_rdata_i), .otp_rvalid_i(otp_rvalid_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Macro model: programs OR in (wdata & wmask); reads answer one cycle after accept.
  logic [Width-1:0] mem [Depth];
  logic             suppress;
  logic             inject;
  logic [Width-1:0] wmask;
  int               wr_cnt = 0;
  int               rd_cnt = 0;
  logic [AW-1:0]    last_wr;
  logic [AW-1:0]    last_rd;

  always @(posedge clk_i) begin
    otp_rvalid_i <= 1'b0;
    otp_rdata_i  <= '0;
    if (inject) begin
      otp_rvalid_i <= 1'b1;
      otp_rdata_i  <= 16'h1234;
    end
    if (rst_ni && otp_valid_o && otp_ready_i) begin
      if (otp_wren_o) begin
        mem[otp_addr_o] = mem[otp_addr_o] | (otp_wdata_o & wmask);
        wr_cnt  = wr_cnt + 1;
        last_wr = otp_addr_o;
      end else begin
        rd_cnt  = rd_cnt + 1;
        last_rd = otp_addr_o;
        if (!suppress) begin
          otp_rvalid_i <= 1'b1;
          otp_rdata_i  <= mem[otp_addr_o];
        end
      end
    end
  end

  typedef struct {
    int               idx;
    logic [Width-1:0] rdata;
    logic             err;
    int               acc;
    int               lat;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   rsp_cnt = 0;
  exp_t me;
  int   midx;
  logic [AW-1:0]    maddr;
  logic [Width-1:0] mwd;
  logic [Width-1:0] mrb;

  // Scoreboard: push expectation on accept, pop and compare on response.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (req_ready_o != '0) begin
        chk("ready_onehot", 32'($countones(req_ready_o)), 1);
        midx = 0;
        for (int b = 0; b < NumReq; b++) if (req_ready_o[b]) midx = b;
        maddr = req_addr_i[midx*AW +: AW];
        mwd   = req_wdata_i[midx*Width +: Width];
        chk("cmd_addr", 32'(otp_addr_o), 32'(maddr));
        grant_log.push_back(midx);
        me.idx = midx;
        me.acc = cyc;
        if (req_wren_i[midx]) begin
          mrb      = mem[maddr] | (mwd & wmask);
          me.rdata = suppress ? '0 : mrb;
          me.err   = suppress ? 1'b1 : ((mrb & mwd) != mwd);
          me.lat   = suppress ? TO + 3 : 4;
        end else begin
          me.rdata = suppress ? '0 : mem[maddr];
          me.err   = suppress;
          me.lat   = suppress ? TO + 1 : 2;
        end
        sb.push_back(me);
      end
      if (rsp_valid_o != '0) begin
        rsp_cnt++;
        if (sb.size() == 0) begin
          chk("rsp_spurious", 32'(rsp_valid_o), 0);
        end else begin
          me = sb.pop_front();
          chk("rsp_valid", 32'(rsp_valid_o), 32'(1 << me.idx));
          chk("rsp_rdata", 32'(rsp_rdata_o), 32'(me.rdata));
          chk("rsp_err", 32'(rsp_err_o), 32'(me.err));
          chk("rsp_latency", 32'(cyc - me.acc), 32'(me.lat));
        end
      end
    end
  end

  task automatic issue(input int idx, input logic wren, input logic [AW-1:0] addr,
                       input logic [Width-1:0] wd);
    logic acc;
    acc = 1'b0;
    req_wren_i[idx] = wren;
    req_addr_i[idx*AW +: AW] = addr;
    req_wdata_i[idx*Width +: Width] = wd;
    req_valid_i[idx] = 1'b1;
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge clk_i);
      acc = req_ready_o[idx];
    end
    chk("issue_accept", 32'(acc), 1);
    @(posedge clk_i); #1;
    req_valid_i[idx] = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && sb.size() != 0; n++) @(posedge clk_i);
    #1;
    chk("drain", 32'(sb.size()), 0);
    @(posedge clk_i); #1;
  endtask

  task automatic do_init();
    chk("reinit_req", 32'(otp_init_req_o), 1);
    otp_init_done_i = 1'b1;
    @(negedge clk_i);
    chk("init_done_pre", 32'(init_done_o), 0);
    @(posedge clk_i); #1;
    chk("init_done_rise", 32'({init_done_o, otp_init_req_o}), 32'(2'b10));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0, w0, r0;
    rst_ni = 1'b0;
    req_valid_i = '0; req_wren_i = '0; req_addr_i = '0; req_wdata_i = '0;
    otp_init_done_i = 1'b0; otp_ready_i = 1'b1;
    suppress = 1'b0; inject = 1'b0; wmask = 16'hFFFF;
    for (int i = 0; i < Depth; i++) mem[i] = '0;

    repeat (3) @(posedge clk_i); #1;
    chk("rst_ctl", 32'({init_done_o, otp_init_req_o, otp_valid_o, otp_wren_o,
                        req_ready_o, rsp_valid_o, rsp_err_o}), 0);
    chk("rst_data", 32'({otp_addr_o, rsp_rdata_o}), 0);

    // Init with everybody requesting: nothing may be granted.
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    req_addr_i  = {10'h012, 10'h011, 10'h010};
    req_valid_i = 3'b111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      chk("init_hold", 32'({otp_init_req_o, init_done_o, req_ready_o}), 32'(5'b10000));
    end
    @(posedge clk_i); #1;
    req_valid_i = '0;
    do_init();
    otp_init_done_i = 1'b0;
    repeat (3) @(posedge clk_i); #1;
    chk("init_sticky", 32'(init_done_o), 1);

    // Single read.
    mem[10'h005] = 16'hA5A5;
    issue(0, 1'b0, 10'h005, '0);
    drain();

    // Round robin: last grant was 0, so order continues from 1.
    mem[10'h010] = 16'h0010; mem[10'h011] = 16'h0011; mem[10'h012] = 16'h0012;
    req_wren_i  = '0;
    req_addr_i  = {10'h012, 10'h011, 10'h010};
    grant_log.delete();
    req_valid_i = 3'b111;
    for (int n = 0; n < 200 && grant_log.size() < 6; n++) begin
      @(posedge clk_i); #1;
    end
    req_valid_i = '0;
    drain();
    chk("rr_count", 32'(grant_log.size()), 6);
    for (int k = 0; k < grant_log.size() && k < 6; k++)
      chk("rr_order", 32'(grant_log[k]), 32'((1 + k) % 3));

    // After a req2 grant, req0 must beat req2.
    issue(2, 1'b0, 10'h030, '0);
    drain();
    grant_log.delete();
    req_addr_i  = {10'h012, 10'h011, 10'h010};
    req_valid_i = 3'b101;
    for (int n = 0; n < 200 && grant_log.size() < 2; n++) begin
      @(posedge clk_i); #1;
    end
    req_valid_i = '0;
    drain();
    chk("pair_count", 32'(grant_log.size()), 2);
    if (grant_log.size() >= 2) begin
      chk("pair_first", 32'(grant_log[0]), 0);
      chk("pair_second", 32'(grant_log[1]), 2);
    end

    // Program that verifies.
    mem[10'h3FF] = 16'h0F00;
    w0 = wr_cnt; r0 = rd_cnt;
    issue(1, 1'b1, 10'h3FF, 16'h00F0);
    drain();
    chk("pgm_writes", 32'(wr_cnt - w0), 1);
    chk("pgm_reads", 32'(rd_cnt - r0), 1);
    chk("pgm_wr_addr", 32'(last_wr), 32'h3FF);
    chk("pgm_rd_addr", 32'(last_rd), 32'h3FF);

    // Program where bit 4 does not stick.
    wmask = 16'hFFEF;
    issue(2, 1'b1, 10'h100, 16'h00F0);
    drain();
    wmask = 16'hFFFF;

    // Read timeout, then a late rvalid that must be ignored.
    suppress = 1'b1;
    mem[10'h020] = 16'h1111;
    issue(0, 1'b0, 10'h020, '0);
    drain();
    suppress = 1'b0;
    c0 = rsp_cnt;
    inject = 1'b1;
    @(posedge clk_i); #1;
    inject = 1'b0;
    repeat (5) @(posedge clk_i); #1;
    chk("late_rvalid", 32'(rsp_cnt - c0), 0);

    // Reset while waiting for read-back data.
    suppress = 1'b1;
    issue(1, 1'b1, 10'h055, 16'h0003);
    @(posedge clk_i); #1;
    chk("vfy_cmd", 32'({otp_valid_o, otp_wren_o, otp_addr_o}), 32'({1'b1, 1'b0, 10'h055}));
    @(posedge clk_i); #1;
    chk("vfy_wait_bus", 32'(otp_valid_o), 0);
    #2;
    c0 = rsp_cnt;
    rst_ni = 1'b0;
    #1;
    chk("rst_mid_ctl", 32'({init_done_o, otp_init_req_o, otp_valid_o, otp_wren_o,
                            req_ready_o, rsp_valid_o, rsp_err_o}), 0);
    chk("rst_mid_data", 32'({otp_addr_o, rsp_rdata_o}), 0);
    sb.delete();
    repeat (3) @(posedge clk_i); #1;
    rst_ni = 1'b1;
    suppress = 1'b0;
    @(posedge clk_i); #1;
    do_init();
    otp_init_done_i = 1'b0;
    repeat (4) @(posedge clk_i); #1;
    chk("rst_no_rsp", 32'(rsp_cnt - c0), 0);

    // Back in service after re-init.
    issue(2, 1'b0, 10'h005, '0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
